// File: rtl/sparc_control_unit_pkg.sv
// rtl/sparc_control_unit_pkg.sv - shared states, field codes and mux select constants for the SPARC control unit
package sparc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RST, S_F0, S_F1, S_F2, S_F3, S_DEC,
        S_ALU, S_EA, S_LM, S_LW, S_LR, S_SD, S_SM,
        S_BR, S_CALL, S_PCU, S_HALT
    } state_t;

    localparam logic [5:0] FETCH_OP_DEF    = 6'h08;
    localparam logic [5:0] ADD_OP_DEF      = 6'h00;
    localparam int         MFC_TIMEOUT_DEF = 16;

    // IR[31:30] major opcode
    localparam logic [1:0] OP_BRANCH = 2'd0;
    localparam logic [1:0] OP_CALL   = 2'd1;
    localparam logic [1:0] OP_ALU    = 2'd2;
    localparam logic [1:0] OP_MEM    = 2'd3;

    // IR[24:22] op2 for format-2; only Bicc is implemented
    localparam logic [2:0] OP2_BICC = 3'b010;

    // IR[24:19] op3 for the two memory ops handled; IR[21] alone separates them
    localparam logic [5:0] OP3_LD = 6'h00;
    localparam logic [5:0] OP3_ST = 6'h04;

    localparam logic [1:0] NPC_INC  = 2'd0;
    localparam logic [1:0] NPC_TBR  = 2'd1;
    localparam logic [1:0] NPC_BTGT = 2'd2;
    localparam logic [1:0] NPC_ALU  = 2'd3;

    localparam logic [1:0] ALU_RS2    = 2'd0;
    localparam logic [1:0] ALU_SIMM13 = 2'd1;
    localparam logic [1:0] ALU_IMM7   = 2'd2;
    localparam logic [1:0] ALU_IMM22  = 2'd3;

    localparam logic [1:0] CIN_PC  = 2'd0;
    localparam logic [1:0] CIN_NPC = 2'd1;
    localparam logic [1:0] CIN_ALU = 2'd2;
    localparam logic [1:0] CIN_MDR = 2'd3;

    localparam logic [1:0] RC_RD  = 2'd0;
    localparam logic [1:0] RC_R18 = 2'd1;
    localparam logic [1:0] RC_R17 = 2'd2;
    localparam logic [1:0] RC_R15 = 2'd3;

    localparam logic [1:0] MDR_RAM  = 2'd0;
    localparam logic [1:0] MDR_RFA  = 2'd1;
    localparam logic [1:0] MDR_AUX  = 2'd2;
    localparam logic [1:0] MDR_ZERO = 2'd3;

    // States that hold MFA high waiting on memory
    function automatic logic is_wait(input state_t s);
        return (s == S_F1) || (s == S_LM) || (s == S_SM);
    endfunction

endpackage

// File: rtl/sparc_control_unit_if.sv
// rtl/sparc_control_unit_if.sv - control unit to datapath/memory signal bundle
interface sparc_control_unit_if;
    logic [31:0] IR;
    logic        MFC;
    logic        N, Z, V, C;
    logic        IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE;
    logic        ClrPC;
    logic        MFA;
    logic        MOP_SEL, AOP_SEL;
    logic [5:0]  OP1;
    logic        MAR_SEL, RA_SEL, BAUX, DISP_SEL;
    logic [1:0]  nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MDR_SEL;
    logic        Halted, Err;

    modport master (
        input  IR, MFC, N, Z, V, C,
        output IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE, ClrPC, MFA,
               MOP_SEL, AOP_SEL, OP1, MAR_SEL, RA_SEL, BAUX, DISP_SEL,
               nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MDR_SEL, Halted, Err
    );

    modport slave (
        output IR, MFC, N, Z, V, C,
        input  IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE, ClrPC, MFA,
               MOP_SEL, AOP_SEL, OP1, MAR_SEL, RA_SEL, BAUX, DISP_SEL,
               nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL, MDR_SEL, Halted, Err
    );
endinterface

// File: rtl/sparc_control_unit_cond_eval.sv
// rtl/sparc_control_unit_cond_eval.sv - SPARC integer condition code evaluation for Bicc
module sparc_cond_eval (
    input  logic [3:0] cond,
    input  logic       N,
    input  logic       Z,
    input  logic       V,
    input  logic       C,
    output logic       taken
);
    logic base;

    // Lower three bits pick the test; cond[3] inverts it (bn/ba, be/bne, ...)
    always_comb begin
        base = 1'b0;
        case (cond[2:0])
            3'd0: base = 1'b0;
            3'd1: base = Z;
            3'd2: base = Z | (N ^ V);
            3'd3: base = N ^ V;
            3'd4: base = C | Z;
            3'd5: base = C;
            3'd6: base = N;
            3'd7: base = V;
            default: base = 1'b0;
        endcase
        taken = base ^ cond[3];
    end
endmodule

// File: rtl/sparc_control_unit.sv
// rtl/sparc_control_unit.sv - microsequenced SPARC control unit (fetch, ALU, ld/st, Bicc, call)
module sparc_control_unit
    import sparc_ctrl_pkg::*;
#(
    parameter logic [5:0] FETCH_OP    = FETCH_OP_DEF,
    parameter logic [5:0] ADD_OP      = ADD_OP_DEF,
    parameter int         MFC_TIMEOUT = MFC_TIMEOUT_DEF
) (
    input logic                  Clk,
    input logic                  Reset,
    sparc_control_unit_if.master bus
);
    localparam int CW = $clog2(MFC_TIMEOUT) + 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            err_q;
    logic            taken;
    logic            timed_out;
    logic [1:0]      alu_sel_imm;
    logic            unused_ir_bits;

    assign unused_ir_bits = ^{bus.IR[29], bus.IR[20:14], bus.IR[12:0]};

    sparc_cond_eval u_cond (
        .cond  (bus.IR[28:25]),
        .N     (bus.N),
        .Z     (bus.Z),
        .V     (bus.V),
        .C     (bus.C),
        .taken (taken)
    );

    assign timed_out   = !bus.MFC && (cnt == CW'(MFC_TIMEOUT - 1));
    assign alu_sel_imm = bus.IR[13] ? ALU_SIMM13 : ALU_RS2;

    // State register, per-wait cycle counter (zero on entry to every wait state) and sticky timeout flag
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_RST;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (is_wait(state) && !bus.MFC)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (is_wait(state) && timed_out)
                err_q <= 1'b1;
        end
    end

    // Next-state and Moore output decode; everything idles (enables high, selects zero) unless a state says otherwise
    always_comb begin
        state_nxt   = state;
        bus.IRE     = 1'b1;
        bus.MDRE    = 1'b1;
        bus.MARE    = 1'b1;
        bus.PCE     = 1'b1;
        bus.nPCE    = 1'b1;
        bus.PSRE    = 1'b1;
        bus.RFE     = 1'b1;
        bus.ClrPC   = 1'b1;
        bus.MFA     = 1'b0;
        bus.MOP_SEL = 1'b0;
        bus.AOP_SEL = 1'b0;
        bus.OP1     = 6'h00;
        bus.MAR_SEL = 1'b0;
        bus.RA_SEL  = 1'b0;
        bus.BAUX    = 1'b0;
        bus.DISP_SEL = 1'b0;
        bus.nPC_SEL = NPC_INC;
        bus.ALU_SEL = ALU_RS2;
        bus.CIN_SEL = CIN_PC;
        bus.RC_SEL  = RC_RD;
        bus.MDR_SEL = MDR_RAM;
        bus.Halted  = 1'b0;
        bus.Err     = err_q;

        case (state)
            S_RST: begin
                bus.ClrPC = 1'b0;
                state_nxt = S_F0;
            end
            S_F0: begin
                bus.MAR_SEL = 1'b1;
                bus.MARE    = 1'b0;
                state_nxt   = S_F1;
            end
            S_F1: begin
                bus.MOP_SEL = 1'b1;
                bus.OP1     = FETCH_OP;
                bus.MFA     = 1'b1;
                if (bus.MFC)        state_nxt = S_F2;
                else if (timed_out) state_nxt = S_HALT;
            end
            S_F2: begin
                bus.MDR_SEL = MDR_RAM;
                bus.MDRE    = 1'b0;
                state_nxt   = S_F3;
            end
            S_F3: begin
                bus.IRE   = 1'b0;
                state_nxt = S_DEC;
            end
            S_DEC: begin
                case (bus.IR[31:30])
                    OP_ALU:    state_nxt = S_ALU;
                    OP_MEM:    state_nxt = S_EA;
                    OP_CALL:   state_nxt = S_CALL;
                    OP_BRANCH: state_nxt = (bus.IR[24:22] == OP2_BICC) ? S_BR : S_HALT;
                    default:   state_nxt = S_HALT;
                endcase
            end
            S_ALU: begin
                bus.ALU_SEL = alu_sel_imm;
                bus.CIN_SEL = CIN_ALU;
                bus.RC_SEL  = RC_RD;
                bus.RFE     = 1'b0;
                bus.PSRE    = ~bus.IR[23];
                state_nxt   = S_PCU;
            end
            S_EA: begin
                bus.AOP_SEL = 1'b1;
                bus.OP1     = ADD_OP;
                bus.ALU_SEL = alu_sel_imm;
                bus.MARE    = 1'b0;
                state_nxt   = bus.IR[21] ? S_SD : S_LM;
            end
            S_LM: begin
                bus.MFA = 1'b1;
                if (bus.MFC)        state_nxt = S_LW;
                else if (timed_out) state_nxt = S_HALT;
            end
            S_LW: begin
                bus.MDR_SEL = MDR_RAM;
                bus.MDRE    = 1'b0;
                state_nxt   = S_LR;
            end
            S_LR: begin
                bus.CIN_SEL = CIN_MDR;
                bus.RFE     = 1'b0;
                state_nxt   = S_PCU;
            end
            S_SD: begin
                bus.RA_SEL  = 1'b1;
                bus.MDR_SEL = MDR_RFA;
                bus.MDRE    = 1'b0;
                state_nxt   = S_SM;
            end
            S_SM: begin
                bus.MFA = 1'b1;
                if (bus.MFC)        state_nxt = S_PCU;
                else if (timed_out) state_nxt = S_HALT;
            end
            S_BR: begin
                if (taken) begin
                    bus.BAUX    = 1'b1;
                    bus.nPC_SEL = NPC_BTGT;
                end
                bus.PCE   = 1'b0;
                bus.nPCE  = 1'b0;
                state_nxt = S_F0;
            end
            S_CALL: begin
                bus.CIN_SEL  = CIN_PC;
                bus.RC_SEL   = RC_R15;
                bus.RFE      = 1'b0;
                bus.BAUX     = 1'b1;
                bus.DISP_SEL = 1'b1;
                bus.nPC_SEL  = NPC_BTGT;
                bus.PCE      = 1'b0;
                bus.nPCE     = 1'b0;
                state_nxt    = S_F0;
            end
            S_PCU: begin
                bus.PCE   = 1'b0;
                bus.nPCE  = 1'b0;
                state_nxt = S_F0;
            end
            S_HALT: begin
                bus.Halted = 1'b1;
                state_nxt  = S_HALT;
            end
            default: state_nxt = S_HALT;
        endcase
    end
endmodule

// File: tb/tb_sparc_control_unit.sv
// tb/tb_sparc_control_unit.sv - scoreboard bench for sparc_control_unit
module tb_sparc_control_unit;

    localparam int ST_RST = 0, ST_F0 = 1, ST_F1 = 2, ST_F2 = 3, ST_F3 = 4, ST_DEC = 5,
                   ST_ALU = 6, ST_EA = 7, ST_LM = 8, ST_LW = 9, ST_LR = 10, ST_SD = 11,
                   ST_SM = 12, ST_BR = 13, ST_CALL = 14, ST_PCU = 15, ST_HALT = 16;

    typedef struct packed {
        logic       ire, mdre, mare, pce, npce, psre, rfe, clrpc, mfa, mop_sel, aop_sel;
        logic [5:0] op1;
        logic       mar_sel, ra_sel, baux, disp_sel;
        logic [1:0] npc_sel, alu_sel, cin_sel, rc_sel, mdr_sel;
        logic       halted, err;
    } outs_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [3:0]  nzvc;
        logic        mfc;
        outs_t       exp;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    item_t       sbq[$];
    item_t       it;
    logic [31:0] cur_ir;
    logic [3:0]  cur_cc;
    logic        cur_take;
    logic        cur_err;
    outs_t       obs;

    sparc_control_unit_if bus ();

    sparc_control_unit dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.IRE, bus.MDRE, bus.MARE, bus.PCE, bus.nPCE, bus.PSRE, bus.RFE, bus.ClrPC,
                  bus.MFA, bus.MOP_SEL, bus.AOP_SEL, bus.OP1, bus.MAR_SEL, bus.RA_SEL, bus.BAUX,
                  bus.DISP_SEL, bus.nPC_SEL, bus.ALU_SEL, bus.CIN_SEL, bus.RC_SEL, bus.MDR_SEL,
                  bus.Halted, bus.Err};

    localparam logic [3:0] BR_COND [12] = '{4'b0001, 4'b0001, 4'b1001, 4'b0011, 4'b0011, 4'b0010,
                                            4'b0100, 4'b1000, 4'b0000, 4'b1010, 4'b1110, 4'b0111};
    localparam logic [3:0] BR_CC   [12] = '{4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b1010, 4'b0000,
                                            4'b0001, 4'b0000, 4'b1111, 4'b0000, 4'b1000, 4'b0010};
    localparam logic       BR_TAKE [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                            1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    function automatic outs_t ref_out(input int st, input logic [31:0] ir, input logic take, input logic err);
        outs_t o;
        o = '0;
        {o.ire, o.mdre, o.mare, o.pce, o.npce, o.psre, o.rfe, o.clrpc} = 8'hFF;
        case (st)
            ST_RST:  o.clrpc = 1'b0;
            ST_F0:   begin o.mar_sel = 1'b1; o.mare = 1'b0; end
            ST_F1:   begin o.mop_sel = 1'b1; o.op1 = 6'h08; o.mfa = 1'b1; end
            ST_F2:   o.mdre = 1'b0;
            ST_F3:   o.ire = 1'b0;
            ST_ALU:  begin o.alu_sel = ir[13] ? 2'd1 : 2'd0; o.cin_sel = 2'd2; o.rfe = 1'b0; o.psre = ~ir[23]; end
            ST_EA:   begin o.aop_sel = 1'b1; o.op1 = 6'h00; o.alu_sel = ir[13] ? 2'd1 : 2'd0; o.mare = 1'b0; end
            ST_LM:   o.mfa = 1'b1;
            ST_LW:   o.mdre = 1'b0;
            ST_LR:   begin o.cin_sel = 2'd3; o.rfe = 1'b0; end
            ST_SD:   begin o.ra_sel = 1'b1; o.mdr_sel = 2'd1; o.mdre = 1'b0; end
            ST_SM:   o.mfa = 1'b1;
            ST_BR:   begin
                if (take) begin o.baux = 1'b1; o.npc_sel = 2'd2; end
                o.pce = 1'b0; o.npce = 1'b0;
            end
            ST_CALL: begin
                o.rc_sel = 2'd3; o.rfe = 1'b0; o.baux = 1'b1; o.disp_sel = 1'b1;
                o.npc_sel = 2'd2; o.pce = 1'b0; o.npce = 1'b0;
            end
            ST_PCU:  begin o.pce = 1'b0; o.npce = 1'b0; end
            ST_HALT: begin o.halted = 1'b1; o.err = err; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic void push(input int st, input logic mfc);
        item_t e;
        e.ir   = cur_ir;
        e.nzvc = cur_cc;
        e.mfc  = mfc;
        e.exp  = ref_out(st, cur_ir, cur_take, cur_err);
        sbq.push_back(e);
    endfunction

    function automatic void push_fetch();
        push(ST_F0, 1'b0);
        push(ST_F1, 1'b1);
        push(ST_F2, 1'b0);
        push(ST_F3, 1'b0);
        push(ST_DEC, 1'b0);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs !== ref_out(ST_RST, 32'h0, 1'b0, 1'b0)) begin
            bad++; $display("FAIL reset_state got=%h want=%h", obs, ref_out(ST_RST, 32'h0, 1'b0, 1'b0));
        end
        @(posedge clk); #1 rst = 1'b0;
        cur_ir = 32'h9E044012; cur_cc = 4'h0; cur_take = 1'b0; cur_err = 1'b0;
        push(ST_RST, 1'b0); push(ST_F0, 1'b0); push(ST_F1, 1'b0); push(ST_F1, 1'b0);
        for (int n = 0; sbq.size() > 0; n++) begin
            it = sbq.pop_front();
            bus.IR = it.ir; {bus.N, bus.Z, bus.V, bus.C} = it.nzvc; bus.MFC = it.mfc;
            @(negedge clk);
            total++;
            if (obs !== it.exp) begin bad++; $display("FAIL reset_seq cyc%0d got=%h want=%h", n, obs, it.exp); end
            @(posedge clk); #1;
        end
        #2;
        total++;
        if (bus.MFA !== 1'b1) begin bad++; $display("FAIL mfa_before_reset got=%b want=1", bus.MFA); end
        rst = 1'b1;
        #1;
        total++;
        if (bus.MFA !== 1'b0) begin bad++; $display("FAIL mfa_async_drop got=%b want=0", bus.MFA); end
        total++;
        if (bus.ClrPC !== 1'b0) begin bad++; $display("FAIL clrpc_async got=%b want=0", bus.ClrPC); end
        @(posedge clk); #1 rst = 1'b0;
        push(ST_RST, 1'b0); push(ST_F0, 1'b0); push(ST_F1, 1'b1);
        for (int n = 0; sbq.size() > 0; n++) begin
            it = sbq.pop_front();
            bus.IR = it.ir; {bus.N, bus.Z, bus.V, bus.C} = it.nzvc; bus.MFC = it.mfc;
            @(negedge clk);
            total++;
            if (obs !== it.exp) begin bad++; $display("FAIL reset_release cyc%0d got=%h want=%h", n, obs, it.exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        cur_cc = 4'h0; cur_take = 1'b0; cur_err = 1'b0;
        cur_ir = 32'h9E044012;
        push(ST_RST, 1'b0); push_fetch(); push(ST_ALU, 1'b0); push(ST_PCU, 1'b0);
        cur_ir = 32'h8A806007;
        push_fetch(); push(ST_ALU, 1'b0); push(ST_PCU, 1'b0); push(ST_F0, 1'b0);
        for (int n = 0; sbq.size() > 0; n++) begin
            it = sbq.pop_front();
            bus.IR = it.ir; {bus.N, bus.Z, bus.V, bus.C} = it.nzvc; bus.MFC = it.mfc;
            @(negedge clk);
            total++;
            if (obs !== it.exp) begin bad++; $display("FAIL alu cyc%0d got=%h want=%h", n, obs, it.exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load();
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        cur_cc = 4'h0; cur_take = 1'b0; cur_err = 1'b0;
        cur_ir = 32'hC200A004;
        push(ST_RST, 1'b0); push_fetch(); push(ST_EA, 1'b0);
        push(ST_LM, 1'b0); push(ST_LM, 1'b0); push(ST_LM, 1'b1);
        push(ST_LW, 1'b0); push(ST_LR, 1'b0); push(ST_PCU, 1'b0); push(ST_F0, 1'b0);
        for (int n = 0; sbq.size() > 0; n++) begin
            it = sbq.pop_front();
            bus.IR = it.ir; {bus.N, bus.Z, bus.V, bus.C} = it.nzvc; bus.MFC = it.mfc;
            @(negedge clk);
            total++;
            if (obs !== it.exp) begin bad++; $display("FAIL load cyc%0d got=%h want=%h", n, obs, it.exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        cur_cc = 4'h0; cur_take = 1'b0; cur_err = 1'b0;
        cur_ir = 32'hC6208005;
        push(ST_RST, 1'b0); push_fetch(); push(ST_EA, 1'b0); push(ST_SD, 1'b0);
        push(ST_SM, 1'b0); push(ST_SM, 1'b1); push(ST_PCU, 1'b0); push(ST_F0, 1'b0);
        for (int n = 0; sbq.size() > 0; n++) begin
            it = sbq.pop_front();
            bus.IR = it.ir; {bus.N, bus.Z, bus.V, bus.C} = it.nzvc; bus.MFC = it.mfc;
            @(negedge clk);
            total++;
            if (obs !== it.exp) begin bad++; $display("FAIL store cyc%0d got=%h want=%h", n, obs, it.exp); end
            total++;
            if (bus.RFE !== 1'b1) begin bad++; $display("FAIL store_rfe cyc%0d got=%b want=1", n, bus.RFE); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        cur_err = 1'b0; cur_take = 1'b0; cur_cc = 4'h0; cur_ir = 32'h0;
        push(ST_RST, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cur_ir = {2'b00, 1'b0, BR_COND[i], 3'b010, 22'h000010};
            cur_cc = BR_CC[i];
            cur_take = BR_TAKE[i];
            push_fetch(); push(ST_BR, 1'b0);
        end
        cur_take = 1'b0;
        cur_ir = 32'h40000010;
        push_fetch(); push(ST_CALL, 1'b0);
        cur_ir = 32'h00000000;
        push_fetch(); push(ST_HALT, 1'b0); push(ST_HALT, 1'b1);
        for (int n = 0; sbq.size() > 0; n++) begin
            it = sbq.pop_front();
            bus.IR = it.ir; {bus.N, bus.Z, bus.V, bus.C} = it.nzvc; bus.MFC = it.mfc;
            @(negedge clk);
            total++;
            if (obs !== it.exp) begin bad++; $display("FAIL branch cyc%0d got=%h want=%h", n, obs, it.exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
        cur_cc = 4'h0; cur_take = 1'b0; cur_err = 1'b0; cur_ir = 32'h9E044012;
        push(ST_RST, 1'b0); push(ST_F0, 1'b0);
        for (int i = 0; i < 16; i++) push(ST_F1, 1'b0);
        cur_err = 1'b1;
        for (int i = 0; i < 4; i++) push(ST_HALT, 1'b1);
        for (int n = 0; sbq.size() > 0; n++) begin
            it = sbq.pop_front();
            bus.IR = it.ir; {bus.N, bus.Z, bus.V, bus.C} = it.nzvc; bus.MFC = it.mfc;
            @(negedge clk);
            total++;
            if (obs !== it.exp) begin bad++; $display("FAIL timeout cyc%0d got=%h want=%h", n, obs, it.exp); end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        total++;
        if (obs !== ref_out(ST_RST, 32'h0, 1'b0, 1'b0)) begin
            bad++; $display("FAIL halt_reset got=%h want=%h", obs, ref_out(ST_RST, 32'h0, 1'b0, 1'b0));
        end
        @(posedge clk); #1 rst = 1'b0;
        cur_err = 1'b0;
        push(ST_RST, 1'b0); push(ST_F0, 1'b0);
        for (int n = 0; sbq.size() > 0; n++) begin
            it = sbq.pop_front();
            bus.IR = it.ir; {bus.N, bus.Z, bus.V, bus.C} = it.nzvc; bus.MFC = it.mfc;
            @(negedge clk);
            total++;
            if (obs !== it.exp) begin bad++; $display("FAIL timeout_recover cyc%0d got=%h want=%h", n, obs, it.exp); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.IR = 32'h0;
        bus.MFC = 1'b0;
        {bus.N, bus.Z, bus.V, bus.C} = 4'h0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
